// File: rtl/dtc_pkg.sv
// Purpose: node-word layout, FSM states and node decode for the decision-tree engine.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package dtc_pkg;

  typedef enum logic [1:0] {IDLE, WALK, DONE} state_t;

  // Node word is {leaf, fidx, child0, child1}, MSB first.
  function automatic int c1_lsb();
    return 0;
  endfunction

  function automatic int c0_lsb(input int node_w);
    return node_w;
  endfunction

  function automatic int fidx_lsb(input int node_w);
    return 2 * node_w;
  endfunction

  function automatic int leaf_pos(input int fidx_w, input int node_w);
    return fidx_w + 2 * node_w;
  endfunction

  function automatic int word_w(input int fidx_w, input int node_w);
    return leaf_pos(fidx_w, node_w) + 1;
  endfunction

  // Decoded fields, widened so one struct serves any parameter set.
  typedef struct packed {
    logic        leaf;
    logic [31:0] fidx;
    logic [31:0] child0;
    logic [31:0] child1;
    logic [31:0] cls;
  } node_t;

  // Class is the low class_w bits of {child0, child1}, i.e. of the word itself.
  function automatic node_t node_decode(input logic [63:0] word, input int fidx_w,
                                        input int node_w, input int class_w);
    node_t       n;
    logic [63:0] nmask;
    logic [63:0] fmask;
    logic [63:0] cmask;
    nmask    = (64'd1 << node_w) - 64'd1;
    fmask    = (64'd1 << fidx_w) - 64'd1;
    cmask    = (64'd1 << class_w) - 64'd1;
    n.child1 = 32'((word >> c1_lsb()) & nmask);
    n.child0 = 32'((word >> c0_lsb(node_w)) & nmask);
    n.fidx   = 32'((word >> fidx_lsb(node_w)) & fmask);
    n.leaf   = |((word >> leaf_pos(fidx_w, node_w)) & 64'd1);
    n.cls    = 32'(word & cmask);
    return n;
  endfunction

endpackage

// File: rtl/dtc_node_table.sv
// Purpose: reset-initialised node register file, one write port, one async read port.
// Latency: write lands on the next edge; read is combinational.
// Backpressure: writes are dropped while busy is high.
module dtc_node_table #(
  parameter int N_NODES = 64,
  parameter int NODE_W  = 6,
  parameter int WORD_W  = 17
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              busy,
  input  logic              we,
  input  logic [NODE_W-1:0] waddr,
  input  logic [WORD_W-1:0] wdata,
  input  logic [NODE_W-1:0] raddr,
  output logic [WORD_W-1:0] rdata
);

  // Leaf flag is the word MSB; all other bits zero gives "leaf, class 0".
  localparam logic [WORD_W-1:0] RST_WORD = {1'b1, {(WORD_W-1){1'b0}}};

  logic [WORD_W-1:0] mem [N_NODES];
  logic              wr_en;

  assign wr_en = we & ~busy;
  assign rdata = mem[raddr];

  // Table storage: cleared to leaf/class 0 on reset, written when not busy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_NODES; i++) mem[i] <= RST_WORD;
    end else if (wr_en) begin
      mem[waddr] <= wdata;
    end
  end

endmodule

// File: rtl/dtc_tree_engine.sv
// Purpose: programmable decision-tree classifier walking one node per clock from node 0.
// Latency: out_valid rises K cycles after accept (K = nodes visited, 1..MAX_DEPTH).
// Backpressure: result held in DONE until out_ready; no new accept until then.
module dtc_tree_engine #(
  parameter int N_FEAT    = 11,
  parameter int CLASS_W   = 3,
  parameter int N_NODES   = 64,
  parameter int MAX_DEPTH = 16,
  parameter int FIDX_W    = $clog2(N_FEAT),
  parameter int NODE_W    = $clog2(N_NODES)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         cfg_we,
  input  logic [NODE_W-1:0]            cfg_addr,
  input  logic [1+FIDX_W+2*NODE_W-1:0] cfg_wdata,
  output logic                         cfg_busy,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [N_FEAT-1:0]            in_feat,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [CLASS_W-1:0]           out_class,
  output logic                         out_err
);
  import dtc_pkg::*;

  localparam int WORD_W  = word_w(FIDX_W, NODE_W);
  localparam int DEPTH_W = $clog2(MAX_DEPTH + 1);

  state_t              state_q, state_d;
  logic [N_FEAT-1:0]   feat_q;
  logic [NODE_W-1:0]   cur_q;
  logic [DEPTH_W-1:0]  depth_q;
  logic [CLASS_W-1:0]  class_q;
  logic                err_q;
  logic [WORD_W-1:0]   rd_word;
  node_t               node;
  logic                bad_fidx;
  logic                last_node;
  logic                feat_bit;
  logic [NODE_W-1:0]   next_cur;
  logic                unused_node_bits;

  dtc_node_table #(
    .N_NODES (N_NODES),
    .NODE_W  (NODE_W),
    .WORD_W  (WORD_W)
  ) u_table (
    .clk   (clk),
    .rst_n (rst_n),
    .busy  (cfg_busy),
    .we    (cfg_we),
    .waddr (cfg_addr),
    .wdata (cfg_wdata),
    .raddr (cur_q),
    .rdata (rd_word)
  );

  assign out_class = class_q;
  assign out_err   = err_q;
  assign unused_node_bits = ^{node.fidx[31:FIDX_W], node.child0[31:NODE_W],
                              node.child1[31:NODE_W], node.cls[31:CLASS_W]};

  // Decode the current node and pick the branch; the depth limit counts this node.
  always_comb begin
    node      = node_decode(64'(rd_word), FIDX_W, NODE_W, CLASS_W);
    bad_fidx  = node.fidx >= 32'(N_FEAT);
    feat_bit  = feat_q[node.fidx[FIDX_W-1:0]];
    next_cur  = feat_bit ? node.child1[NODE_W-1:0] : node.child0[NODE_W-1:0];
    last_node = depth_q >= DEPTH_W'(MAX_DEPTH - 1);
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state and handshake outputs.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    cfg_busy  = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = WALK;
      end
      WALK: begin
        cfg_busy = 1'b1;
        if (node.leaf || bad_fidx || last_node) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Walk datapath: latch features, step the node pointer, count depth, capture result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      feat_q  <= '0;
      cur_q   <= '0;
      depth_q <= '0;
      class_q <= '0;
      err_q   <= 1'b0;
    end else if (state_q == IDLE) begin
      if (in_valid) begin
        feat_q  <= in_feat;
        cur_q   <= '0;
        depth_q <= '0;
      end
    end else if (state_q == WALK) begin
      if (depth_q != '1) depth_q <= depth_q + 1'b1;
      if (node.leaf) begin
        class_q <= node.cls[CLASS_W-1:0];
        err_q   <= 1'b0;
      end else if (bad_fidx || last_node) begin
        class_q <= '0;
        err_q   <= 1'b1;
      end else begin
        cur_q <= next_cur;
      end
    end
  end

endmodule

// File: tb/tb_dtc_tree_engine.sv
module tb_dtc_tree_engine;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cfg_we;
  logic [5:0]  cfg_addr;
  logic [16:0] cfg_wdata;
  logic        cfg_busy;
  logic        in_valid;
  logic        in_ready;
  logic [10:0] in_feat;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  out_class;
  logic        out_err;

  int n_cmp  = 0;
  int n_fail = 0;

  dtc_tree_engine dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_wdata (cfg_wdata),
    .cfg_busy  (cfg_busy),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_feat   (in_feat),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_class (out_class),
    .out_err   (out_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          do_cfg;
    logic [5:0]  addr;
    logic [16:0] wdata;
    bit          do_run;
    logic [10:0] feat;
    int          cls;
    int          err;
    int          k;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [16:0] mk(input bit leaf, input int fidx, input int c0, input int c1);
    return {leaf, 4'(fidx), 6'(c0), 6'(c1)};
  endfunction

  function automatic vec_t cfgv(input int addr, input logic [16:0] w);
    vec_t v;
    v = '{do_cfg: 1'b1, addr: 6'(addr), wdata: w, do_run: 1'b0, feat: '0, cls: 0, err: 0, k: 0};
    return v;
  endfunction

  function automatic vec_t runv(input logic [10:0] f, input int c, input int e, input int k);
    vec_t v;
    v = '{do_cfg: 1'b0, addr: '0, wdata: '0, do_run: 1'b1, feat: f, cls: c, err: e, k: k};
    return v;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // All tasks start and end at posedge+1.
  task automatic cfg_write(input logic [5:0] a, input logic [16:0] w);
    cfg_we = 1'b1; cfg_addr = a; cfg_wdata = w;
    @(posedge clk); #1;
    cfg_we = 1'b0;
  endtask

  task automatic wait_out(output int k);
    k = 0;
    do begin
      @(posedge clk); #1;
      k++;
    end while (!out_valid && k < 40);
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("post_hs_out_valid", out_valid, 0);
    check("post_hs_in_ready", in_ready, 1);
  endtask

  task automatic run(input logic [10:0] f, input int c, input int e, input int k_exp);
    int k;
    check("accept_in_ready", in_ready, 1);
    in_valid = 1'b1; in_feat = f;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_out(k);
    check("latency_k", k, k_exp);
    check("out_class", out_class, c);
    check("out_err", out_err, e);
    handshake();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    rst_n = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
    in_valid = 1'b0; in_feat = '0; out_ready = 1'b0;

    // Directed table.
    tbl.push_back(runv(11'h7FF, 0, 0, 1));
    tbl.push_back(cfgv(0, mk(0, 5, 1, 2)));
    tbl.push_back(cfgv(1, mk(1, 0, 0, 0)));
    tbl.push_back(cfgv(2, mk(1, 0, 0, 3)));
    tbl.push_back(runv(11'h020, 3, 0, 2));
    tbl.push_back(runv(11'h000, 0, 0, 2));
    tbl.push_back(runv(11'h7DF, 0, 0, 2));
    tbl.push_back(runv(11'h7FF, 3, 0, 2));
    tbl.push_back(cfgv(2, mk(1, 0, 7, 6'h3B)));
    tbl.push_back(runv(11'h020, 3, 0, 2));
    tbl.push_back(cfgv(0, mk(0, 11, 1, 2)));
    tbl.push_back(runv(11'h7FF, 0, 1, 1));
    tbl.push_back(cfgv(0, mk(0, 15, 1, 2)));
    tbl.push_back(runv(11'h000, 0, 1, 1));
    tbl.push_back(cfgv(0, mk(0, 10, 1, 2)));
    tbl.push_back(runv(11'h400, 3, 0, 2));
    tbl.push_back(runv(11'h3FF, 0, 0, 2));
    for (int i = 0; i <= 20; i++) tbl.push_back(cfgv(i, mk(0, i % 11, i + 1, i + 1)));
    tbl.push_back(runv(11'h5A5, 0, 1, 16));
    tbl.push_back(cfgv(15, mk(1, 0, 0, 5)));
    tbl.push_back(runv(11'h000, 5, 0, 16));
    tbl.push_back(cfgv(15, mk(0, 3, 16, 16)));
    tbl.push_back(cfgv(16, mk(1, 0, 0, 4)));
    tbl.push_back(runv(11'h7FF, 0, 1, 16));
    tbl.push_back(cfgv(0, mk(0, 5, 1, 2)));
    tbl.push_back(cfgv(1, mk(1, 0, 0, 0)));
    tbl.push_back(cfgv(2, mk(1, 0, 0, 3)));
    tbl.push_back(runv(11'h020, 3, 0, 2));

    // Reset state.
    #12;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_class", out_class, 0);
    check("rst_out_err", out_err, 0);
    check("rst_cfg_busy", cfg_busy, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    foreach (tbl[i]) begin
      if (tbl[i].do_cfg) cfg_write(tbl[i].addr, tbl[i].wdata);
      if (tbl[i].do_run) run(tbl[i].feat, tbl[i].cls, tbl[i].err, tbl[i].k);
    end

    // Backpressure: result held stable for 5 cycles.
    in_valid = 1'b1; in_feat = 11'h020;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_out(k);
    check("bp_latency", k, 2);
    for (int i = 0; i < 5; i++) begin
      check("bp_out_valid", out_valid, 1);
      check("bp_out_class", out_class, 3);
      check("bp_out_err", out_err, 0);
      check("bp_in_ready", in_ready, 0);
      @(posedge clk); #1;
    end
    handshake();

    // Config write during WALK is dropped.
    in_valid = 1'b1; in_feat = 11'h020;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("walk_cfg_busy", cfg_busy, 1);
    cfg_write(6'd2, mk(1, 0, 0, 5));
    k = 1;
    while (!out_valid && k < 40) begin
      @(posedge clk); #1;
      k++;
    end
    check("drop_latency", k, 2);
    check("drop_class", out_class, 3);
    handshake();
    cfg_write(6'd2, mk(1, 0, 0, 5));
    run(11'h020, 5, 0, 2);

    // Write and accept in the same IDLE cycle: walk sees the new node.
    cfg_we = 1'b1; cfg_addr = 6'd2; cfg_wdata = mk(1, 0, 0, 6);
    in_valid = 1'b1; in_feat = 11'h020;
    @(posedge clk); #1;
    cfg_we = 1'b0; in_valid = 1'b0;
    wait_out(k);
    check("same_cycle_latency", k, 2);
    check("same_cycle_class", out_class, 6);
    handshake();

    // Reset mid-walk.
    in_valid = 1'b1; in_feat = 11'h020;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("pre_rst_busy", cfg_busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_out_valid", out_valid, 0);
    check("arst_in_ready", in_ready, 1);
    check("arst_cfg_busy", cfg_busy, 0);
    check("arst_out_class", out_class, 0);
    check("arst_out_err", out_err, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("aborted_no_output", out_valid, 0);
    end
    run(11'h020, 0, 0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
